// File: rtl/gerador_aleatorio_if.sv
// Request/response bundle of the pseudo-random generator.
// pedido is a level request taken only while idle; pronto pulses one cycle when aleatorio is updated.
interface gerador_aleatorio_if #(
  parameter int LFSR_W = 8,
  parameter int OUT_W  = 4
) ();
  logic [LFSR_W-1:0] semente;
  logic              carrega;
  logic              pedido;
  logic [OUT_W-1:0]  aleatorio;
  logic              pronto;
  logic              ocupado;
  logic [LFSR_W-1:0] lfsr_q;
  logic [1:0]        estado;

  modport master (
    output semente, carrega, pedido,
    input  aleatorio, pronto, ocupado, lfsr_q, estado
  );

  modport slave (
    input  semente, carrega, pedido,
    output aleatorio, pronto, ocupado, lfsr_q, estado
  );
endinterface

// File: rtl/gerador_aleatorio.sv
// Range-constrained pseudo-random value generator: free-running Fibonacci LFSR,
// serial LSB-first candidate collection, reject-and-retry with fallback to MIN_VAL.
module gerador_aleatorio #(
  parameter int                LFSR_W    = 8,
  parameter int                OUT_W     = 4,
  parameter logic [LFSR_W-1:0] TAPS      = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED_RST  = 8'hA5,
  parameter int                MIN_VAL   = 1,
  parameter int                MAX_VAL   = 14,
  parameter int                MAX_TRIES = 4
) (
  input logic                clock,
  input logic                reset,
  gerador_aleatorio_if.slave bus
);

  localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [OUT_W-1:0] MIN_C = OUT_W'(MIN_VAL);
  localparam logic [OUT_W-1:0] MAX_C = OUT_W'(MAX_VAL);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    COLETA = 2'd1,
    TESTE  = 2'd2
  } estado_t;

  estado_t           r_state, w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [BW-1:0]     r_bit, w_bit_nxt;
  logic [TW-1:0]     r_try, w_try_nxt;
  logic [OUT_W-1:0]  r_cand, w_cand_nxt;
  logic [OUT_W-1:0]  r_val, w_val_nxt;
  logic              r_pronto, w_pronto_nxt;
  logic              w_fb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= OCIOSO;
      r_lfsr   <= SEED_RST;
      r_bit    <= '0;
      r_try    <= '0;
      r_cand   <= '0;
      r_val    <= MIN_C;
      r_pronto <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_bit    <= w_bit_nxt;
      r_try    <= w_try_nxt;
      r_cand   <= w_cand_nxt;
      r_val    <= w_val_nxt;
      r_pronto <= w_pronto_nxt;
    end
  end

  // The LFSR runs regardless of the FSM; a zero seed or a zero state re-seeds.
  always_comb begin
    w_fb = ^(r_lfsr & TAPS);
    if (bus.carrega)
      w_lfsr_nxt = (bus.semente == '0) ? SEED_RST : bus.semente;
    else if (r_lfsr == '0)
      w_lfsr_nxt = SEED_RST;
    else
      w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_fb};
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_try_nxt    = r_try;
    w_cand_nxt   = r_cand;
    w_val_nxt    = r_val;
    w_pronto_nxt = 1'b0;
    if (bus.carrega) begin
      w_state_nxt = OCIOSO;
    end else begin
      case (r_state)
        OCIOSO: begin
          if (bus.pedido) begin
            w_state_nxt = COLETA;
            w_bit_nxt   = '0;
            w_try_nxt   = '0;
            w_cand_nxt  = '0;
          end
        end
        COLETA: begin
          w_cand_nxt[r_bit] = r_lfsr[0];
          w_bit_nxt         = r_bit + 1'b1;
          if (r_bit == BW'(OUT_W - 1))
            w_state_nxt = TESTE;
        end
        TESTE: begin
          if ((r_cand >= MIN_C) && (r_cand <= MAX_C)) begin
            w_val_nxt    = r_cand;
            w_pronto_nxt = 1'b1;
            w_state_nxt  = OCIOSO;
          end else if (r_try == TW'(MAX_TRIES - 1)) begin
            w_val_nxt    = MIN_C;
            w_pronto_nxt = 1'b1;
            w_state_nxt  = OCIOSO;
          end else begin
            w_try_nxt   = r_try + 1'b1;
            w_bit_nxt   = '0;
            w_state_nxt = COLETA;
          end
        end
        default: w_state_nxt = OCIOSO;
      endcase
    end
  end

  assign bus.aleatorio = r_val;
  assign bus.pronto    = r_pronto;
  assign bus.ocupado   = (r_state != OCIOSO);
  assign bus.lfsr_q    = r_lfsr;
  assign bus.estado    = r_state;

endmodule

// File: tb/tb_gerador_aleatorio.sv
// Self-checking bench for gerador_aleatorio: directed vector table, corner sequences,
// and randomized back-to-back requests against a sequence-level reference model.
module tb_gerador_aleatorio;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         TRIES = 4;

  logic clock;
  logic reset = 1'b1;

  gerador_aleatorio_if #(.LFSR_W(8), .OUT_W(4)) b1 ();
  gerador_aleatorio_if #(.LFSR_W(8), .OUT_W(4)) b2 ();

  assign b2.semente = b1.semente;
  assign b2.carrega = b1.carrega;
  assign b2.pedido  = b1.pedido;

  gerador_aleatorio #(
    .LFSR_W(8), .OUT_W(4), .TAPS(TAPS), .SEED_RST(SEED),
    .MIN_VAL(1), .MAX_VAL(14), .MAX_TRIES(TRIES)
  ) dut1 (.clock(clock), .reset(reset), .bus(b1));

  gerador_aleatorio #(
    .LFSR_W(8), .OUT_W(4), .TAPS(TAPS), .SEED_RST(SEED),
    .MIN_VAL(3), .MAX_VAL(3), .MAX_TRIES(TRIES)
  ) dut2 (.clock(clock), .reset(reset), .bus(b2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_lfsr;
  logic [3:0] last_val;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       c;
    logic [7:0] sd;
    logic       p;
    logic [7:0] e_lfsr;
    logic       e_pronto;
    logic       e_ocup;
    logic [3:0] e_val;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int v;
    v = int'(s);
    return 8'(((v << 1) & 255) | ($countones(s & TAPS) & 1));
  endfunction

  // Walks the bit stream seen after the accepting edge: each try eats OUT_W bits
  // plus one test edge; the value is the first in-range candidate or the minimum.
  function automatic void predict(input logic [7:0] s0, input int mn, input int mx,
                                  output logic [3:0] val, output int lat);
    logic [7:0] s;
    int cand;
    s   = s0;
    lat = 0;
    val = 4'(mn);
    for (int t = 0; t < TRIES; t++) begin
      cand = 0;
      for (int i = 0; i < 4; i++) begin
        cand = cand + (int'(s[0]) << i);
        s = lfsr_next(s);
      end
      s   = lfsr_next(s);
      lat = lat + 5;
      if (cand >= mn && cand <= mx) begin
        val = 4'(cand);
        return;
      end
    end
  endfunction

  // One clock edge: inputs are stable from #1 after the previous edge; model then follows.
  task automatic tick();
    logic       c;
    logic [7:0] sd;
    c  = b1.carrega;
    sd = b1.semente;
    @(posedge clock);
    #1;
    if (c)                m_lfsr = (sd == 8'h00) ? SEED : sd;
    else if (m_lfsr == 0) m_lfsr = SEED;
    else                  m_lfsr = lfsr_next(m_lfsr);
    check("lfsr_q", int'(b1.lfsr_q), int'(m_lfsr));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    b1.carrega = 1'b0;
    b1.pedido  = 1'b0;
    b1.semente = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    m_lfsr = SEED;
  endtask

  initial begin
    logic [3:0] ev;
    int         el;
    int         lat;
    b1.carrega = 1'b0;
    b1.pedido  = 1'b0;
    b1.semente = 8'h00;

    tbl[0] = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 4'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 4'd1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 4'd1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b1, 4'd1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 4'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h23, 1'b0, 1'b1, 4'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h47, 1'b1, 1'b0, 4'd8};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h8E, 1'b0, 1'b0, 4'd8};
    tbl[8] = '{1'b1, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd8};

    do_reset();
    check("rst_lfsr", int'(b1.lfsr_q), int'(SEED));
    check("rst_val", int'(b1.aleatorio), 1);
    check("rst_pronto", int'(b1.pronto), 0);
    check("rst_ocupado", int'(b1.ocupado), 0);

    // Single-value window [3,3]: only a 3 hit or the fallback may come out.
    b1.carrega = 1'b1; b1.semente = 8'h01;
    tick();
    b1.carrega = 1'b0; b1.pedido = 1'b1;
    tick();
    b1.pedido = 1'b0;
    predict(m_lfsr, 3, 3, ev, el);
    lat = 0;
    while (!b2.pronto && lat < 30) begin
      tick();
      lat++;
    end
    check("win3_pronto", int'(b2.pronto), 1);
    check("win3_latency", lat, el);
    check("win3_val", int'(b2.aleatorio), 3);
    check("win3_bound", int'(lat <= 20), 1);

    do_reset();
    for (int k = 0; k < 9; k++) begin
      b1.carrega = tbl[k].c;
      b1.semente = tbl[k].sd;
      b1.pedido  = tbl[k].p;
      tick();
      check($sformatf("vec%0d_lfsr", k), int'(b1.lfsr_q), int'(tbl[k].e_lfsr));
      check($sformatf("vec%0d_pronto", k), int'(b1.pronto), int'(tbl[k].e_pronto));
      check($sformatf("vec%0d_ocupado", k), int'(b1.ocupado), int'(tbl[k].e_ocup));
      check($sformatf("vec%0d_val", k), int'(b1.aleatorio), int'(tbl[k].e_val));
    end
    b1.carrega = 1'b0;
    last_val = 4'd8;

    for (int k = 0; k < 300; k++) begin
      tick();
      check("nonzero_lfsr", int'(b1.lfsr_q != 8'h00), 1);
    end

    // Load pulse in the middle of a collection aborts it silently.
    b1.pedido = 1'b1;
    tick();
    b1.pedido = 1'b0;
    tick();
    tick();
    check("abort_busy", int'(b1.ocupado), 1);
    b1.carrega = 1'b1; b1.semente = 8'h3C;
    tick();
    b1.carrega = 1'b0;
    check("abort_idle", int'(b1.ocupado), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_pronto", int'(b1.pronto), 0);
      check("abort_val_held", int'(b1.aleatorio), int'(last_val));
    end

    // Asynchronous reset mid-collection.
    b1.pedido = 1'b1;
    tick();
    b1.pedido = 1'b0;
    tick();
    check("midrst_busy", int'(b1.ocupado), 1);
    reset = 1'b1;
    #1;
    check("midrst_val", int'(b1.aleatorio), 1);
    check("midrst_ocupado", int'(b1.ocupado), 0);
    check("midrst_lfsr", int'(b1.lfsr_q), int'(SEED));
    do_reset();

    // Back-to-back requests with pedido held high, random seed per block.
    for (int blk = 0; blk < 10; blk++) begin
      b1.pedido  = 1'b0;
      b1.carrega = 1'b1;
      b1.semente = (blk == 3) ? 8'h00 : 8'($urandom_range(0, 255));
      tick();
      b1.carrega = 1'b0;
      b1.pedido  = 1'b1;
      for (int r = 0; r < 100; r++) begin
        tick();
        check("rnd_busy", int'(b1.ocupado), 1);
        predict(m_lfsr, 1, 14, ev, el);
        exp_q.push_back(ev);
        lat = 0;
        do begin
          tick();
          lat++;
        end while (!b1.pronto && lat < 40);
        check("rnd_pronto_seen", int'(b1.pronto), 1);
        ev = exp_q.pop_front();
        check("rnd_latency", lat, el);
        check("rnd_val", int'(b1.aleatorio), int'(ev));
        check("rnd_in_range", int'(b1.aleatorio >= 4'd1 && b1.aleatorio <= 4'd14), 1);
        if (!b1.pronto) break;
      end
    end
    b1.pedido = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gerador_aleatorio.md
Name: gerador_aleatorio

Overview:
Parametrised pseudo-random value generator for the game logic, e.g. food placement on the board grid.
- A free-running Fibonacci LFSR of configurable width supplies one bit per cycle.
- On request, OUT_W bits are collected serially (LSB first) into a candidate.
- Candidates outside [MIN_VAL, MAX_VAL] are rejected and retried; a bounded retry count falls back to MIN_VAL.
- Adds reset, seed load, range constraint and a request/ready handshake.

Parameters:
LFSR_W, 8, LFSR register width (>= OUT_W, >= 3)
OUT_W, 4, output value width
TAPS, 8'hB8, feedback tap mask (bit i set = lfsr[i] in XOR)
SEED_RST, 8'hA5, nonzero LFSR value used at reset and for zero seeds
MIN_VAL, 1, lowest accepted output value
MAX_VAL, 14, highest accepted output value (MIN_VAL <= MAX_VAL < 2^OUT_W)
MAX_TRIES, 4, rejected candidates tolerated before fallback

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
semente  in  LFSR_W  seed value, sampled when carrega=1
carrega  in  1  load semente into the LFSR this edge
pedido  in  1  request a new value (level, sampled in OCIOSO only)
aleatorio  out  OUT_W  last accepted value, held between requests
pronto  out  1  one-cycle pulse: aleatorio updated this cycle
ocupado  out  1  high while in COLETA or TESTE
lfsr_q  out  LFSR_W  current LFSR state (observability)

Behaviour:
- Reset (async, while high):
  - lfsr = SEED_RST.
  - aleatorio = MIN_VAL.
  - pronto = 0; FSM = OCIOSO.
  - Bit counter, retry counter and candidate are cleared.
- LFSR advances every edge, independent of FSM state:
  - fb = XOR-reduce(lfsr & TAPS).
  - lfsr <= {lfsr[LFSR_W-2:0], fb}.
- carrega=1 has priority over shifting:
  - lfsr <= semente; if semente == 0, lfsr <= SEED_RST instead.
  - FSM returns to OCIOSO, aborting any collection; no pronto is issued.
  - pedido is ignored on that edge.
- Lock-up guard: if lfsr is ever 0 outside load, the next edge forces SEED_RST.
- FSM states:
  - OCIOSO: pedido=1 -> COLETA; bit counter = 0; retry counter = 0.
  - COLETA: each edge, cand[bit] <= lfsr[0] (value before the edge) and bit++. After OUT_W captures -> TESTE.
  - TESTE (one edge):
    - If MIN_VAL <= cand <= MAX_VAL: aleatorio <= cand, pronto <= 1, -> OCIOSO.
    - Else if retries+1 == MAX_TRIES: aleatorio <= MIN_VAL, pronto <= 1, -> OCIOSO.
    - Else: retries++, -> COLETA with bit counter = 0.
- pronto is high for exactly one cycle per request, registered.
- ocupado = (state != OCIOSO), combinational from state.
- Latency, counted from the sampling edge of pedido:
  - OUT_W capture edges plus 1 TESTE edge; pronto is high after edge OUT_W+1.
  - Each retry adds OUT_W+1 edges.
- pedido held high continuously issues back-to-back requests; the next one is accepted on the edge after pronto.
- pedido while ocupado is ignored; it is not queued.
- Reset asserted mid-collection discards the candidate; aleatorio reverts to MIN_VAL.

Test Plan:
- Reset, then release with carrega=0 -> lfsr_q=8'hA5, aleatorio=1, pronto=0, ocupado=0.
- carrega=1, semente=8'h01 for one edge, then idle -> lfsr_q sequence 01, 02, 04, 08, 11 on successive edges.
- carrega=1, semente=8'h00 -> lfsr_q=8'hA5 after the edge; lock-up never occurs over 300 cycles.
- Seed 8'h01 at edge e0, pedido=1 sampled at e1 -> captures at e2..e5 give bits 0,0,0,1; pronto pulses after e6 with aleatorio=4'h8; ocupado high between e1 and e6.
- MIN_VAL=MAX_VAL=3, MAX_TRIES=4, seed 8'h01, single request -> candidates != 3 are rejected; pronto appears only after 3 hit or 4 rejects; final aleatorio=3 in both cases; latency <= 4*(OUT_W+1) edges.
- carrega pulse during COLETA -> FSM to OCIOSO, no pronto, aleatorio unchanged. Also: pedido held high for 1000 requests -> every aleatorio in [1,14], none equal to 0 or 15.
